// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state encoding, opcode constants and ALU op table for the multi-cycle sequencer.
package multicycle_control_fsm_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5,
    FAULT  = 3'd6
  } state_t;
  localparam logic [2:0] OP_RTYPE  = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_STORE  = 3'd5;
  localparam logic [2:0] OP_BRANCH = 3'd6;
  localparam logic [2:0] ALU_BRANCH = 3'b001;
  function automatic logic [2:0] aluOpFor(input logic [2:0] op);
    return op == 3'd0 ? 3'b000 :
           op == 3'd1 ? 3'b010 :
           op == 3'd2 ? 3'b101 :
           op == 3'd3 ? 3'b100 :
           op == 3'd6 ? 3'b001 : 3'b011;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_timeout.sv
// mcfsm_timeout_counter: memory wait counter with clear, enable and terminal-count compare.
module mcfsm_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  logic [7:0] count;
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable) count <= count + 8'd1;
  end
  assign terminal = count == 8'(LIMIT);
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-timeout fault trap.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                inp_clk,
  input  logic                inp_rst,
  input  logic [OPCODE_W-1:0] inp_opCode,
  input  logic                inp_zero,
  input  logic                inp_memReady,
  output logic                out_iorD,
  output logic                out_irWrite,
  output logic                out_pcWrite,
  output logic                out_pcSrc,
  output logic                out_regDst,
  output logic                out_aluSrc,
  output logic                out_memToReg,
  output logic                out_regWrite,
  output logic                out_memRead,
  output logic                out_memWrite,
  output logic [ALUOP_W-1:0]  out_aluOp,
  output logic                out_instrDone,
  output logic                out_fault
);
  state_t state, nextState;
  logic [OPCODE_W-1:0] opQ;
  logic waiting, timedOut, live;
  assign waiting = state == FETCH || state == MEM;
  // Counter clears whenever no access is pending or the access completes, so it starts at 0 on entry to FETCH/MEM.
  mcfsm_timeout_counter #(.LIMIT(MEM_TIMEOUT)) uTimeout (
    .clk(inp_clk),
    .rst(inp_rst),
    .clear(!waiting || inp_memReady),
    .enable(waiting && !inp_memReady),
    .terminal(timedOut)
  );
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state <= FETCH;
      opQ   <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) opQ <= inp_opCode;
    end
  end
  always_comb begin
    nextState = FAULT;
    case (state)
      FETCH:       nextState = inp_memReady ? DECODE : timedOut ? FAULT : FETCH;
      DECODE:      nextState = inp_opCode == OP_BRANCH ? BRANCH : EXEC;
      EXEC:        nextState = (opQ == OP_LOAD || opQ == OP_STORE) ? MEM : WB;
      MEM:         nextState = inp_memReady ? (opQ == OP_STORE ? FETCH : WB) : timedOut ? FAULT : MEM;
      WB, BRANCH:  nextState = FETCH;
      default:     nextState = FAULT;
    endcase
  end
  // Reset gates every output so an abandoned instruction issues no strobes.
  assign live          = !inp_rst;
  assign out_iorD      = live && state == MEM;
  assign out_irWrite   = live && state == FETCH && inp_memReady;
  assign out_pcWrite   = live && ((state == FETCH && inp_memReady) || (state == BRANCH && inp_zero));
  assign out_pcSrc     = live && state == BRANCH;
  assign out_regDst    = live && state == WB && opQ == OP_RTYPE;
  assign out_aluSrc    = live && state == EXEC && opQ != OP_RTYPE;
  assign out_memToReg  = live && state == WB && opQ == OP_LOAD;
  assign out_regWrite  = live && state == WB;
  assign out_memRead   = live && (state == FETCH || (state == MEM && opQ == OP_LOAD));
  assign out_memWrite  = live && state == MEM && opQ == OP_STORE;
  assign out_aluOp     = !live ? '0 : state == EXEC ? aluOpFor(opQ) : state == BRANCH ? ALU_BRANCH : '0;
  assign out_instrDone = live && (state == WB || state == BRANCH ||
                                  (state == MEM && opQ == OP_STORE && inp_memReady));
  assign out_fault     = live && state == FAULT;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed vectors with a per-cycle output scoreboard and an instruction-latency scoreboard.
module tb_multicycle_control_fsm;
  logic clk = 0, rst = 1, zero = 0, memReady = 0;
  logic [2:0] opCode = 0;
  logic iorD, irWrite, pcWrite, pcSrc, regDst, aluSrc, memToReg, regWrite, memRead, memWrite, instrDone, fault;
  logic [2:0] aluOp;
  int checks = 0, fails = 0, cyc = 0, cycleNo = 0;
  typedef struct { logic [14:0] v; int idx; } exp_t;
  exp_t expQ[$];
  int latQ[$];
  int stepNo = 0;
  localparam logic [14:0] IORD = 15'h4000, IRW = 15'h2000, PCW = 15'h1000, PCS = 15'h0800;
  localparam logic [14:0] RDST = 15'h0400, ASRC = 15'h0200, M2R = 15'h0100, RW = 15'h0080;
  localparam logic [14:0] MRD = 15'h0040, MWR = 15'h0020, DONE = 15'h0002, FLT = 15'h0001;
  localparam logic [14:0] FETCHED = MRD | IRW | PCW;
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .inp_clk(clk), .inp_rst(rst), .inp_opCode(opCode), .inp_zero(zero), .inp_memReady(memReady),
    .out_iorD(iorD), .out_irWrite(irWrite), .out_pcWrite(pcWrite), .out_pcSrc(pcSrc),
    .out_regDst(regDst), .out_aluSrc(aluSrc), .out_memToReg(memToReg), .out_regWrite(regWrite),
    .out_memRead(memRead), .out_memWrite(memWrite), .out_aluOp(aluOp),
    .out_instrDone(instrDone), .out_fault(fault)
  );
  wire [14:0] got = {iorD, irWrite, pcWrite, pcSrc, regDst, aluSrc, memToReg, regWrite,
                     memRead, memWrite, aluOp, instrDone, fault};
  function automatic logic [14:0] alu(input logic [2:0] a);
    return {10'b0, a, 2'b0};
  endfunction
  task automatic step(input logic r, input logic [2:0] op, input logic rdy, input logic z, input logic [14:0] e);
    @(posedge clk);
    #1;
    rst = r;
    opCode = op;
    memReady = rdy;
    zero = z;
    expQ.push_back('{e, stepNo});
    stepNo++;
  endtask
  always @(negedge clk) begin
    exp_t e;
    int l;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL outputs step %0d: got %h expected %h", e.idx, got, e.v);
      end
    end
    if (rst) cyc = 0;
    else begin
      cyc++;
      if (instrDone) begin
        checks++;
        if (latQ.size() == 0) begin
          fails++;
          $display("FAIL latency: unexpected instrDone after %0d cycles, expected none", cyc);
        end else begin
          l = latQ.pop_front();
          if (cyc != l) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, l);
          end
        end
        cyc = 0;
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    latQ.push_back(4);
    step(0, 0, 1, 0, FETCHED);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, alu(3'b000));
    step(0, 0, 0, 0, RW | RDST | DONE);
    latQ.push_back(7);
    step(0, 4, 1, 0, FETCHED);
    step(0, 4, 0, 0, 0);
    step(0, 4, 0, 0, ASRC | alu(3'b011));
    step(0, 4, 0, 0, IORD | MRD);
    step(0, 4, 0, 0, IORD | MRD);
    step(0, 4, 1, 0, IORD | MRD);
    step(0, 4, 0, 0, RW | M2R | DONE);
    latQ.push_back(4);
    step(0, 5, 1, 0, FETCHED);
    step(0, 5, 0, 0, 0);
    step(0, 5, 0, 0, ASRC | alu(3'b011));
    step(0, 5, 1, 0, IORD | MWR | DONE);
    latQ.push_back(4);
    step(0, 2, 1, 0, FETCHED);
    step(0, 2, 0, 0, 0);
    step(0, 2, 0, 0, ASRC | alu(3'b101));
    step(0, 2, 0, 0, RW | DONE);
    latQ.push_back(3);
    step(0, 6, 1, 1, FETCHED);
    step(0, 6, 0, 1, 0);
    step(0, 6, 0, 1, alu(3'b001) | PCS | PCW | DONE);
    latQ.push_back(3);
    step(0, 6, 1, 0, FETCHED);
    step(0, 6, 0, 0, 0);
    step(0, 6, 0, 0, alu(3'b001) | PCS | DONE);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, MRD);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, FLT);
    step(1, 0, 0, 0, 0);
    step(0, 4, 1, 0, FETCHED);
    step(0, 4, 0, 0, 0);
    step(0, 4, 0, 0, ASRC | alu(3'b011));
    step(0, 4, 0, 0, IORD | MRD);
    step(1, 4, 0, 0, 0);
    latQ.push_back(5);
    step(0, 1, 0, 0, MRD);
    step(0, 1, 1, 0, FETCHED);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, ASRC | alu(3'b010));
    step(0, 1, 0, 0, RW | DONE);
    step(0, 0, 0, 0, MRD);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (latQ.size() != 0 || expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d latencies and %0d vectors pending, expected 0 and 0", latQ.size(), expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
